// File: rtl/vmem_text_writer.sv
// vmem_text_writer: character-stream front end for the character video memory.
// Accepts ASCII bytes over valid/ready, keeps a text cursor, turns printable
// bytes into one-cycle memory writes and interprets CR, LF, BS and FF.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_data/in_valid    byte from the text source
//   in_ready            byte can be accepted this cycle (combinational)
//   vm_rw/row/col/data  write port to videomem (rw=1 means write)
//   cur_row/cur_col     current cursor position
//   busy                full-screen clear in progress
module vmem_text_writer #(
  parameter int unsigned COLS           = 160,
  parameter int unsigned ROWS           = 60,
  parameter logic [7:0]  FILL_CHAR      = 8'd32,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       vm_rw,
  output logic [7:0] vm_row,
  output logic [7:0] vm_col,
  output logic [7:0] vm_data,
  output logic [7:0] cur_row,
  output logic [7:0] cur_col,
  output logic       busy
);

  localparam int unsigned CW      = 8;
  localparam logic [CW-1:0] COL_MAX = CW'(COLS - 1);
  localparam logic [CW-1:0] ROW_MAX = CW'(ROWS - 1);

  localparam logic [7:0] CH_BS = 8'h08;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_FF = 8'h0C;
  localparam logic [7:0] CH_CR = 8'h0D;

  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;
  localparam state_t RST_STATE = CLEAR_ON_RESET ? CLEAR : IDLE;

  state_t        state_q, state_d;
  logic [CW-1:0] clr_row_q, clr_row_d;
  logic [CW-1:0] clr_col_q, clr_col_d;
  logic          vm_rw_d;
  logic [CW-1:0] vm_row_d, vm_col_d, cur_row_d, cur_col_d;
  logic [7:0]    vm_data_d;

  logic          accept_c;
  logic          printable_c;
  logic          clr_last_c;
  logic [CW-1:0] row_inc_c;

  assign in_ready    = (state_q == IDLE) && rst_n;
  assign busy        = (state_q == CLEAR);
  assign accept_c    = in_valid && in_ready;
  assign printable_c = (in_data >= 8'h20) && (in_data <= 8'h7E);
  assign clr_last_c  = (clr_row_q == ROW_MAX) && (clr_col_q == COL_MAX);
  // Next row with wrap to the top (no scrolling).
  assign row_inc_c   = (cur_row == ROW_MAX) ? '0 : cur_row + 8'd1;

  // State and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RST_STATE;
      clr_row_q <= '0;
      clr_col_q <= '0;
      vm_rw     <= 1'b0;
      vm_row    <= '0;
      vm_col    <= '0;
      vm_data   <= '0;
      cur_row   <= '0;
      cur_col   <= '0;
    end else begin
      state_q   <= state_d;
      clr_row_q <= clr_row_d;
      clr_col_q <= clr_col_d;
      vm_rw     <= vm_rw_d;
      vm_row    <= vm_row_d;
      vm_col    <= vm_col_d;
      vm_data   <= vm_data_d;
      cur_row   <= cur_row_d;
      cur_col   <= cur_col_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (accept_c && (in_data == CH_FF)) state_d = CLEAR;
      CLEAR: if (clr_last_c) state_d = IDLE;
    endcase
  end

  // Write port, cursor and clear-counter updates.
  always_comb begin
    vm_rw_d   = 1'b0;
    vm_row_d  = vm_row;
    vm_col_d  = vm_col;
    vm_data_d = vm_data;
    cur_row_d = cur_row;
    cur_col_d = cur_col;
    clr_row_d = clr_row_q;
    clr_col_d = clr_col_q;
    case (state_q)
      CLEAR: begin
        vm_rw_d   = 1'b1;
        vm_row_d  = clr_row_q;
        vm_col_d  = clr_col_q;
        vm_data_d = FILL_CHAR;
        if (clr_last_c) begin
          clr_row_d = '0;
          clr_col_d = '0;
          cur_row_d = '0;
          cur_col_d = '0;
        end else if (clr_col_q == COL_MAX) begin
          clr_col_d = '0;
          clr_row_d = clr_row_q + 8'd1;
        end else begin
          clr_col_d = clr_col_q + 8'd1;
        end
      end
      IDLE: begin
        if (accept_c) begin
          if (printable_c) begin
            vm_rw_d   = 1'b1;
            vm_row_d  = cur_row;
            vm_col_d  = cur_col;
            vm_data_d = in_data;
            if (cur_col == COL_MAX) begin
              cur_col_d = '0;
              cur_row_d = row_inc_c;
            end else begin
              cur_col_d = cur_col + 8'd1;
            end
          end else begin
            case (in_data)
              CH_CR: cur_col_d = '0;
              CH_LF: begin
                cur_col_d = '0;
                cur_row_d = row_inc_c;
              end
              CH_BS: begin
                // Erase the cell the cursor moves back onto; no-op at (0,0).
                if (cur_col != '0) begin
                  cur_col_d = cur_col - 8'd1;
                  vm_rw_d   = 1'b1;
                end else if (cur_row != '0) begin
                  cur_row_d = cur_row - 8'd1;
                  cur_col_d = COL_MAX;
                  vm_rw_d   = 1'b1;
                end
                if (vm_rw_d) begin
                  vm_row_d  = cur_row_d;
                  vm_col_d  = cur_col_d;
                  vm_data_d = FILL_CHAR;
                end
              end
              default: ;
            endcase
          end
        end
      end
    endcase
  end

endmodule

// File: tb/tb_vmem_text_writer.sv
// Self-checking bench for vmem_text_writer: vector table, hand-written
// clear/reset sequences and a random byte stream against a linear-cursor model.
module tb_vmem_text_writer;

  localparam int unsigned COLS  = 160;
  localparam int unsigned ROWS  = 60;
  localparam int unsigned CELLS = COLS * ROWS;

  logic       clk;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       vm_rw;
  logic [7:0] vm_row, vm_col, vm_data, cur_row, cur_col;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;
  int pos      = 0;   // model cursor as linear cell index row*COLS+col

  vmem_text_writer #(.COLS(COLS), .ROWS(ROWS), .FILL_CHAR(8'd32), .CLEAR_ON_RESET(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .vm_rw(vm_rw), .vm_row(vm_row), .vm_col(vm_col), .vm_data(vm_data),
    .cur_row(cur_row), .cur_col(cur_col), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  b;
    logic [63:0] exp;
  } vec_t;

  // Write fields are only meaningful when rw is high, so they are zeroed otherwise.
  function automatic logic [63:0] pack(input logic w, input logic [7:0] r, input logic [7:0] c,
                                       input logic [7:0] d, input logic [7:0] cr, input logic [7:0] cc);
    return {23'd0, w, (w ? r : 8'd0), (w ? c : 8'd0), (w ? d : 8'd0), cr, cc};
  endfunction

  function automatic logic [63:0] observed();
    return pack(vm_rw, vm_row, vm_col, vm_data, cur_row, cur_col);
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reference model: cursor as a linear index into the row-major screen.
  task automatic model(input logic [7:0] b, output logic [63:0] e);
    logic       w;
    logic [7:0] d;
    int         wp;
    w = 1'b0; d = 8'd0; wp = 0;
    if (b >= 8'h20 && b <= 8'h7E) begin
      w = 1'b1; wp = pos; d = b;
      pos = (pos + 1) % CELLS;
    end else if (b == 8'h0D) begin
      pos = pos - (pos % COLS);
    end else if (b == 8'h0A) begin
      pos = ((pos / COLS + 1) % ROWS) * COLS;
    end else if (b == 8'h08) begin
      if (pos > 0) begin
        pos = pos - 1;
        w = 1'b1; wp = pos; d = 8'h20;
      end
    end
    e = pack(w, 8'(wp / COLS), 8'(wp % COLS), d, 8'(pos / COLS), 8'(pos % COLS));
  endtask

  // Present one byte for one cycle and compare the result.
  task automatic send(input string name, input logic [7:0] b, input logic [63:0] e);
    check({name, " ready"}, 64'(in_ready), 64'd1);
    in_data  = b;
    in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    check(name, observed(), e);
  endtask

  task automatic send_model(input string name, input logic [7:0] b);
    logic [63:0] e;
    model(b, e);
    send(name, b, e);
  endtask

  // Called just after the edge on which the block is in CLEAR; follows n writes.
  task automatic check_clear(input string name, input int n);
    int bad_hs = 0;
    int bad_wr = 0;
    for (int i = 0; i < n; i++) begin
      if (!(busy === 1'b1 && in_ready === 1'b0)) bad_hs++;
      cyc();
      if (vm_rw !== 1'b1 || vm_row !== 8'(i / COLS) || vm_col !== 8'(i % COLS) || vm_data !== 8'h20) begin
        if (bad_wr == 0)
          $display("FAIL %s first bad write %0d: rw=%b row=%0d col=%0d data=%h", name, i, vm_rw, vm_row, vm_col, vm_data);
        bad_wr++;
      end
    end
    check({name, " busy/ready"}, 64'(bad_hs), 64'd0);
    check({name, " writes"}, 64'(bad_wr), 64'd0);
    if (n == int'(CELLS))
      check({name, " end"}, 64'({busy, in_ready, cur_row, cur_col}), 64'({1'b0, 1'b1, 16'h0000}));
  endtask

  vec_t tbl[$];

  initial begin
    logic [63:0] e;
    logic [7:0]  b;
    vec_t        v;

    // Vectors from a cleared screen, cursor at (0,0).
    v.b = 8'h48; v.exp = pack(1, 0, 0, 8'h48, 0, 1);     tbl.push_back(v);
    v.b = 8'h69; v.exp = pack(1, 0, 1, 8'h69, 0, 2);     tbl.push_back(v);
    v.b = 8'h07; v.exp = pack(0, 0, 0, 0, 0, 2);         tbl.push_back(v);
    v.b = 8'h08; v.exp = pack(1, 0, 1, 8'h20, 0, 1);     tbl.push_back(v);
    v.b = 8'h0D; v.exp = pack(0, 0, 0, 0, 0, 0);         tbl.push_back(v);
    v.b = 8'h08; v.exp = pack(0, 0, 0, 0, 0, 0);         tbl.push_back(v);
    v.b = 8'h0A; v.exp = pack(0, 0, 0, 0, 1, 0);         tbl.push_back(v);
    v.b = 8'h0A; v.exp = pack(0, 0, 0, 0, 2, 0);         tbl.push_back(v);
    v.b = 8'h0A; v.exp = pack(0, 0, 0, 0, 3, 0);         tbl.push_back(v);
    v.b = 8'h08; v.exp = pack(1, 2, 159, 8'h20, 2, 159); tbl.push_back(v);
    v.b = 8'h78; v.exp = pack(1, 2, 159, 8'h78, 3, 0);   tbl.push_back(v);
    v.b = 8'h7F; v.exp = pack(0, 0, 0, 0, 3, 0);         tbl.push_back(v);
    v.b = 8'hFF; v.exp = pack(0, 0, 0, 0, 3, 0);         tbl.push_back(v);
    v.b = 8'h20; v.exp = pack(1, 3, 0, 8'h20, 3, 1);     tbl.push_back(v);
    v.b = 8'h7E; v.exp = pack(1, 3, 1, 8'h7E, 3, 2);     tbl.push_back(v);
    v.b = 8'h1F; v.exp = pack(0, 0, 0, 0, 3, 2);         tbl.push_back(v);
    v.b = 8'h0A; v.exp = pack(0, 0, 0, 0, 4, 0);         tbl.push_back(v);
    v.b = 8'h0A; v.exp = pack(0, 0, 0, 0, 5, 0);         tbl.push_back(v);
    for (int k = 0; k < 7; k++) begin
      v.b = 8'(8'h61 + k); v.exp = pack(1, 5, 8'(k), 8'(8'h61 + k), 5, 8'(k + 1)); tbl.push_back(v);
    end
    v.b = 8'h0A; v.exp = pack(0, 0, 0, 0, 6, 0);         tbl.push_back(v);
    v.b = 8'h19; v.exp = pack(0, 0, 0, 0, 6, 0);         tbl.push_back(v);
    v.b = 8'h0D; v.exp = pack(0, 0, 0, 0, 6, 0);         tbl.push_back(v);

    // Reset and power-on clear.
    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (3) cyc();
    check("reset outputs", 64'({vm_rw, vm_row, vm_col, vm_data, cur_row, cur_col, busy, in_ready}),
          64'({1'b0, 40'd0, 1'b1, 1'b0}));
    rst_n = 1'b1;
    check_clear("init clear", int'(CELLS));
    pos = 0;

    // Table vectors, applied back to back.
    for (int i = 0; i < tbl.size(); i++) begin
      model(tbl[i].b, e);
      send($sformatf("tbl[%0d]", i), tbl[i].b, tbl[i].exp);
    end

    // Walk to (59,159) and check the bottom-right wrap.
    for (int i = 0; i < 53; i++) send_model("walk lf", 8'h0A);
    for (int i = 0; i < 159; i++) send_model("walk chr", 8'($urandom_range(32, 126)));
    check("at bottom right", 64'({cur_row, cur_col}), 64'({8'd59, 8'd159}));
    model(8'h41, e);
    send("wrap A", 8'h41, pack(1, 59, 159, 8'h41, 0, 0));

    // Random stream with idle gaps.
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 7) == 0) begin
        in_valid = 1'b0;
        cyc();
        check("idle", observed(), pack(0, 0, 0, 0, 8'(pos / COLS), 8'(pos % COLS)));
      end else begin
        case ($urandom_range(0, 9))
          0, 1, 2, 3, 4, 5: b = 8'($urandom_range(32, 126));
          6: b = 8'h0D;
          7: b = 8'h0A;
          8: b = 8'h08;
          default: b = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(127, 255)) : 8'($urandom_range(0, 7));
        endcase
        send_model($sformatf("rand %0d byte %h", k, b), b);
      end
    end

    // FF with the next byte held valid through the whole clear.
    send_model("pre ff", 8'h51);
    in_data = 8'h0C; in_valid = 1'b1;
    cyc();
    in_data = 8'h5A;
    check("ff edge", 64'({vm_rw, busy, in_ready}), 64'({1'b0, 1'b1, 1'b0}));
    check_clear("ff clear", int'(CELLS));
    cyc();
    in_valid = 1'b0;
    check("held Z", observed(), pack(1, 0, 0, 8'h5A, 0, 1));
    pos = 1;

    // Reset 100 cycles into a clear restarts it from (0,0).
    send_model("pre abort 1", 8'h31);
    send_model("pre abort 2", 8'h32);
    in_data = 8'h0C; in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    check_clear("abort part", 100);
    rst_n = 1'b0;
    #1;
    check("async reset", 64'({vm_rw, vm_row, vm_col, vm_data, cur_row, cur_col, busy, in_ready}),
          64'({1'b0, 40'd0, 1'b1, 1'b0}));
    cyc();
    rst_n = 1'b1;
    check_clear("restart clear", int'(CELLS));
    pos = 0;
    send_model("post restart", 8'h4F);
    send_model("post restart bs", 8'h08);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
